tug_of_war_ctrl: RTL and testbench
==================================

Name: tug_of_war_ctrl

Overview:
Round controller for the tug-of-war game. It sequences a round through idle, countdown, play and win phases, and moves the rope position on player presses. It treats early presses as fouls and holds the result and a tone request for a fixed time. Timing comes from the one-cycle slow enable produced by the clock divider (one pulse every 256 clk); the controller never divides the clock itself.

Parameters:
POS_MAX, 10, highest rope position; positions 0..POS_MAX, centre = POS_MAX/2 (integer division, 5 by default)
CD_TICKS, 3, slow ticks spent in countdown before play starts
WIN_TICKS, 8, slow ticks the win result and tone request are held
PW, 4, width of pos; must satisfy 2^PW > POS_MAX
TW, 4, width of the internal tick counter; must satisfy 2^TW > max(CD_TICKS, WIN_TICKS)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
tick  in  1  slow enable from the divider, one clk wide
start  in  1  start request level, synchronised and debounced upstream
btn_l  in  1  left player button level, synchronised and debounced
btn_r  in  1  right player button level, synchronised and debounced
pos  out  PW  rope position; 0 = left wins, POS_MAX = right wins
phase  out  2  state: 0 IDLE, 1 COUNTDOWN, 2 PLAY, 3 WIN
win_l  out  1  left player won; valid in WIN only
win_r  out  1  right player won; valid in WIN only
foul  out  1  the round ended by an early press
tone_req  out  1  sound request; high in WIN, and for one clk on each accepted move

Behaviour:
- Reset values: phase=IDLE, pos=POS_MAX/2, win_l=win_r=foul=tone_req=0, tick counter=0.
- Reset: synchronous and active-high; it overrides all other inputs, including mid-round.
- Edge detection: registered previous values of start, btn_l and btn_r give rising-edge pulses (rise_s, rise_l, rise_r).
  - Previous-value registers reset to 1. A button held through reset therefore produces no edge.
- IDLE:
  - pos held at centre; win_l, win_r and foul are cleared.
  - rise_s -> COUNTDOWN on the next clk, counter=CD_TICKS.
- COUNTDOWN:
  - Each tick decrements the counter.
  - tick arriving with counter==1 -> PLAY next clk, counter=0.
  - Foul: rise_l -> WIN with win_r=1, foul=1; rise_r -> WIN with win_l=1, foul=1.
  - Both rise together -> foul on both; return to IDLE with no winner and no tone.
  - A foul takes priority over a tick in the same clk.
- PLAY:
  - rise_l alone: pos decrements by 1 and tone_req pulses for 1 clk.
  - rise_r alone: pos increments by 1 and tone_req pulses for 1 clk.
  - Both in the same clk: no move, no tone.
  - tick has no effect in PLAY.
  - Win check uses the new pos, registered: a move that makes pos==0 enters WIN with win_l=1 on the same edge that updates pos; pos==POS_MAX gives win_r=1.
  - pos never underflows or overflows.
  - rise_s is ignored.
- WIN:
  - counter=WIN_TICKS on entry; tone_req held high; pos, win_l, win_r and foul are frozen.
  - Each tick decrements the counter; a tick with counter==1 -> IDLE next clk.
  - On IDLE entry, tone_req=0 and pos returns to centre.
  - Buttons and start are ignored.
- Latency: every output is registered and reflects an input edge one clk after the input rises (one clk after the edge-detect register sees it).
- A tick coinciding with a state change is consumed by the state that is current in that clk.
- Illegal phase values (none exist with 2 bits) are not applicable. An out-of-range pos is impossible by construction; the bench asserts 0<=pos<=POS_MAX.

Test Plan:
- Reset, then idle: pos=5, phase=0, all flags 0. Raise start -> phase=1 next clk. Send 3 ticks -> phase=2 one clk after the 3rd tick.
- In PLAY, 5 separate btn_l presses: pos 5→4→3→2→1→0, tone_req pulses 1 clk on each press. After the 5th press: phase=3, win_l=1, tone_req held. After 8 ticks: phase=0, pos=5, tone_req=0.
- In PLAY, btn_l and btn_r rise in the same clk: pos unchanged, no tone_req pulse. Buttons held high with no new edge: no movement.
- In COUNTDOWN after 1 tick, btn_r rises: phase=3, win_l=1, foul=1. Same clk as a tick: the foul still wins. Both buttons rise together: phase=0, no winner.
- rst asserted mid-PLAY at pos=8 with btn_r held high: next clk pos=5, phase=0. Releasing rst with btn_r still high produces no move and no start.
- tick held high for many clk (stress case): countdown completes after 3 clk and WIN lasts 8 clk; pos is never outside 0..10.

Source files
------------

// File: rtl/tug_of_war_ctrl.sv
// Tug-of-war round controller: idle -> countdown -> play -> win, paced by the
// divider's one-clk slow tick; rope position moves on rising button edges.
module tug_of_war_ctrl #(
    parameter int POS_MAX   = 10,
    parameter int CD_TICKS  = 3,
    parameter int WIN_TICKS = 8,
    parameter int PW        = 4,
    parameter int TW        = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          start,
    input  logic          btn_l,
    input  logic          btn_r,
    output logic [PW-1:0] pos,
    output logic [1:0]    phase,
    output logic          win_l,
    output logic          win_r,
    output logic          foul,
    output logic          tone_req
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CD   = 2'd1,
        ST_PLAY = 2'd2,
        ST_WIN  = 2'd3
    } state_t;

    localparam logic [PW-1:0] POS_TOP  = PW'(POS_MAX);
    localparam logic [PW-1:0] POS_MID  = PW'(POS_MAX / 2);
    localparam logic [PW-1:0] POS_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] POS_ONE  = PW'(1);
    localparam logic [TW-1:0] CNT_CD   = TW'(CD_TICKS);
    localparam logic [TW-1:0] CNT_WIN  = TW'(WIN_TICKS);
    localparam logic [TW-1:0] CNT_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0] CNT_ONE  = TW'(1);

    state_t        state_r, state_nxt_s;
    logic [TW-1:0] cnt_r, cnt_nxt_s;
    logic [PW-1:0] pos_r, pos_nxt_s, mv_pos_s;
    logic          win_l_r, win_l_nxt_s, win_r_r, win_r_nxt_s;
    logic          foul_r, foul_nxt_s, tone_r, tone_nxt_s;
    logic          prev_start_r, prev_l_r, prev_r_r;
    logic          rise_start_s, rise_l_s, rise_r_s, last_tick_s;

    // Previous values reset high so a level already high at reset release is not an edge.
    assign rise_start_s = start & ~prev_start_r;
    assign rise_l_s     = btn_l & ~prev_l_r;
    assign rise_r_s     = btn_r & ~prev_r_r;
    assign last_tick_s  = tick && (cnt_r == CNT_ONE);

    // Candidate rope position after a single-sided press, clamped to the rope ends.
    always_comb begin
        mv_pos_s = pos_r;
        if (rise_l_s && !rise_r_s && (pos_r != POS_ZERO)) begin
            mv_pos_s = pos_r - POS_ONE;
        end else if (rise_r_s && !rise_l_s && (pos_r != POS_TOP)) begin
            mv_pos_s = pos_r + POS_ONE;
        end else begin
            mv_pos_s = pos_r;
        end
    end

    // State, counter, output and edge-detect registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= CNT_ZERO;
            pos_r        <= POS_MID;
            win_l_r      <= 1'b0;
            win_r_r      <= 1'b0;
            foul_r       <= 1'b0;
            tone_r       <= 1'b0;
            prev_start_r <= 1'b1;
            prev_l_r     <= 1'b1;
            prev_r_r     <= 1'b1;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            pos_r        <= pos_nxt_s;
            win_l_r      <= win_l_nxt_s;
            win_r_r      <= win_r_nxt_s;
            foul_r       <= foul_nxt_s;
            tone_r       <= tone_nxt_s;
            prev_start_r <= start;
            prev_l_r     <= btn_l;
            prev_r_r     <= btn_r;
        end
    end

    // Next phase and tick counter; a foul outranks a countdown tick.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (rise_start_s) begin
                    state_nxt_s = ST_CD;
                    cnt_nxt_s   = CNT_CD;
                end else begin
                    cnt_nxt_s = CNT_ZERO;
                end
            end
            ST_CD: begin
                if (rise_l_s && rise_r_s) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (rise_l_s || rise_r_s) begin
                    state_nxt_s = ST_WIN;
                    cnt_nxt_s   = CNT_WIN;
                end else if (last_tick_s) begin
                    state_nxt_s = ST_PLAY;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (tick) begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            ST_PLAY: begin
                if ((mv_pos_s != pos_r) && ((mv_pos_s == POS_ZERO) || (mv_pos_s == POS_TOP))) begin
                    state_nxt_s = ST_WIN;
                    cnt_nxt_s   = CNT_WIN;
                end else begin
                    cnt_nxt_s = CNT_ZERO;
                end
            end
            ST_WIN: begin
                if (last_tick_s) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (tick) begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        pos_nxt_s   = pos_r;
        win_l_nxt_s = win_l_r;
        win_r_nxt_s = win_r_r;
        foul_nxt_s  = foul_r;
        tone_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                pos_nxt_s   = POS_MID;
                win_l_nxt_s = 1'b0;
                win_r_nxt_s = 1'b0;
                foul_nxt_s  = 1'b0;
            end
            ST_CD: begin
                if (rise_l_s && rise_r_s) begin
                    foul_nxt_s = 1'b1;
                end else if (rise_l_s) begin
                    win_r_nxt_s = 1'b1;
                    foul_nxt_s  = 1'b1;
                    tone_nxt_s  = 1'b1;
                end else if (rise_r_s) begin
                    win_l_nxt_s = 1'b1;
                    foul_nxt_s  = 1'b1;
                    tone_nxt_s  = 1'b1;
                end else begin
                    tone_nxt_s = 1'b0;
                end
            end
            ST_PLAY: begin
                pos_nxt_s   = mv_pos_s;
                tone_nxt_s  = (mv_pos_s != pos_r);
                win_l_nxt_s = (mv_pos_s == POS_ZERO);
                win_r_nxt_s = (mv_pos_s == POS_TOP);
            end
            ST_WIN: begin
                if (last_tick_s) begin
                    pos_nxt_s   = POS_MID;
                    win_l_nxt_s = 1'b0;
                    win_r_nxt_s = 1'b0;
                    foul_nxt_s  = 1'b0;
                    tone_nxt_s  = 1'b0;
                end else begin
                    tone_nxt_s = 1'b1;
                end
            end
            default: begin
                pos_nxt_s = POS_MID;
            end
        endcase
    end

    assign pos      = pos_r;
    assign phase    = state_r;
    assign win_l    = win_l_r;
    assign win_r    = win_r_r;
    assign foul     = foul_r;
    assign tone_req = tone_r;

endmodule

// File: tb/tb_tug_of_war_ctrl.sv
// Directed bench for tug_of_war_ctrl: full rounds, fouls, reset mid-round and
// a continuous-tick stress round, all against hand-computed expectations.
module tb_tug_of_war_ctrl;

    logic       clk = 1'b0;
    logic       rst, tick, start, btn_l, btn_r;
    logic [3:0] pos;
    logic [1:0] phase;
    logic       win_l, win_r, foul, tone_req;
    int         n_cmp = 0;
    int         n_bad = 0;

    tug_of_war_ctrl dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start),
        .btn_l(btn_l), .btn_r(btn_r), .pos(pos), .phase(phase),
        .win_l(win_l), .win_r(win_r), .foul(foul), .tone_req(tone_req)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock, settle 1 ns past the edge, and confirm pos stays on the rope.
    task automatic step();
        @(posedge clk);
        #1;
        check_val("pos_range", int'(pos <= 4'd10), 1);
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
    endtask

    task automatic press(input bit left, input int exp_pos, input int exp_phase);
        if (left) btn_l = 1'b1; else btn_r = 1'b1;
        step();
        check_val("press_pos", int'(pos), exp_pos);
        check_val("press_phase", int'(phase), exp_phase);
        check_val("press_tone", int'(tone_req), 1);
        btn_l = 1'b0;
        btn_r = 1'b0;
        step();
    endtask

    task automatic start_round();
        start = 1'b1;
        step();
        check_val("start_phase", int'(phase), 1);
        start = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; start = 1'b0; btn_l = 1'b0; btn_r = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        check_val("rst_pos", int'(pos), 5);
        check_val("rst_phase", int'(phase), 0);
        check_val("rst_flags", int'({win_l, win_r, foul, tone_req}), 0);

        // Round 1: countdown then five left pulls to a left win.
        start_round();
        pulse_tick();
        pulse_tick();
        check_val("cd_phase_2ticks", int'(phase), 1);
        tick = 1'b1;
        step();
        tick = 1'b0;
        check_val("cd_to_play", int'(phase), 2);
        step();
        for (int i = 1; i <= 4; i++) begin
            press(1'b1, 5 - i, 2);
            check_val("tone_pulse_end", int'(tone_req), 0);
        end
        press(1'b1, 0, 3);
        check_val("win_l_set", int'(win_l), 1);
        check_val("win_r_clear", int'(win_r), 0);
        check_val("win_tone_held", int'(tone_req), 1);
        for (int i = 0; i < 7; i++) pulse_tick();
        check_val("win_7ticks", int'(phase), 3);
        tick = 1'b1;
        step();
        tick = 1'b0;
        check_val("win_end_phase", int'(phase), 0);
        check_val("win_end_pos", int'(pos), 5);
        check_val("win_end_tone", int'(tone_req), 0);
        step();
        check_val("idle_win_l", int'(win_l), 0);

        // Round 2: simultaneous rises, held buttons, then reset mid-play.
        start_round();
        for (int i = 0; i < 3; i++) pulse_tick();
        check_val("play2_phase", int'(phase), 2);
        btn_l = 1'b1; btn_r = 1'b1;
        step();
        check_val("both_pos", int'(pos), 5);
        check_val("both_tone", int'(tone_req), 0);
        step();
        check_val("held_pos", int'(pos), 5);
        check_val("held_tone", int'(tone_req), 0);
        btn_l = 1'b0; btn_r = 1'b0;
        step();
        press(1'b0, 6, 2);
        press(1'b0, 7, 2);
        press(1'b0, 8, 2);
        btn_r = 1'b1;
        rst = 1'b1;
        step();
        check_val("midrst_pos", int'(pos), 5);
        check_val("midrst_phase", int'(phase), 0);
        rst = 1'b0;
        step();
        step();
        check_val("post_rst_pos", int'(pos), 5);
        check_val("post_rst_phase", int'(phase), 0);
        check_val("post_rst_tone", int'(tone_req), 0);
        btn_r = 1'b0;
        step();

        // Round 3: right player jumps the gun on the same clk as a tick.
        start_round();
        pulse_tick();
        btn_r = 1'b1; tick = 1'b1;
        step();
        btn_r = 1'b0; tick = 1'b0;
        check_val("foul_phase", int'(phase), 3);
        check_val("foul_win_l", int'(win_l), 1);
        check_val("foul_win_r", int'(win_r), 0);
        check_val("foul_flag", int'(foul), 1);
        check_val("foul_tone", int'(tone_req), 1);
        for (int i = 0; i < 8; i++) pulse_tick();
        check_val("foul_end_phase", int'(phase), 0);
        check_val("foul_end_flag", int'(foul), 0);

        // Round 4: both players foul together.
        start_round();
        btn_l = 1'b1; btn_r = 1'b1;
        step();
        btn_l = 1'b0; btn_r = 1'b0;
        check_val("dbl_foul_phase", int'(phase), 0);
        check_val("dbl_foul_win", int'({win_l, win_r}), 0);
        check_val("dbl_foul_tone", int'(tone_req), 0);
        step();

        // Round 5: tick held high the whole time.
        tick = 1'b1;
        start = 1'b1;
        step();
        check_val("stress_cd", int'(phase), 1);
        start = 1'b0;
        step();
        step();
        check_val("stress_cd_2clk", int'(phase), 1);
        step();
        check_val("stress_play", int'(phase), 2);
        for (int i = 6; i <= 9; i++) press(1'b0, i, 2);
        btn_r = 1'b1;
        step();
        btn_r = 1'b0;
        check_val("stress_win_pos", int'(pos), 10);
        check_val("stress_win_phase", int'(phase), 3);
        check_val("stress_win_r", int'(win_r), 1);
        for (int i = 0; i < 7; i++) step();
        check_val("stress_win_7clk", int'(phase), 3);
        step();
        check_val("stress_idle", int'(phase), 0);
        check_val("stress_idle_pos", int'(pos), 5);
        tick = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
